// File: rtl/bmp_ctrl_pkg.sv
// Shared types for the bitmap placer control path: opcode and arbiter state encodings.
package bmp_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_ADD_IMG = 2'b00,
      OP_REM_IMG = 2'b01,
      OP_ADD_FNT = 2'b10,
      OP_RSVD    = 2'b11
   } bmp_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE
   } arb_state_t;

   localparam int unsigned NUM_FONT_CHARS = 42;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational round-robin pick: first requester strictly after last_gnt, wrapping to the lowest index.
module rr_arbiter_comb #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_gnt,
   output logic          valid,
   output logic [IW-1:0] gnt_idx
);

   logic [N-1:0]  hi_req;
   logic          lo_hit, hi_hit;
   logic [IW-1:0] lo_idx, hi_idx;

   // Requests above last_gnt take precedence; otherwise wrap to the lowest set bit.
   always_comb begin
      hi_req = '0;
      lo_hit = 1'b0;
      hi_hit = 1'b0;
      lo_idx = '0;
      hi_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         hi_req[i] = req[i] && (i > 32'(last_gnt));
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !lo_hit) begin
            lo_hit = 1'b1;
            lo_idx = IW'(i);
         end
         if (hi_req[i] && !hi_hit) begin
            hi_hit = 1'b1;
            hi_idx = IW'(i);
         end
      end
      valid   = lo_hit;
      gnt_idx = hi_hit ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/bmp_place_arbiter.sv
// Round-robin sharing of the bitmap placer between NREQ requesters, with strobe issue,
// completion tracking and a watchdog on the placer's busy time.
module bmp_place_arbiter
   import bmp_ctrl_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 131072,
   parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    cmd_op,
   input  logic [6*NREQ-1:0]    cmd_indx,
   input  logic [10*NREQ-1:0]   cmd_x,
   input  logic [9*NREQ-1:0]    cmd_y,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      err,
   output logic                 add_img,
   output logic                 rem_img,
   output logic                 add_fnt,
   output logic [4:0]           image_indx,
   output logic [5:0]           fnt_indx,
   output logic [9:0]           xloc,
   output logic [8:0]           yloc,
   input  logic                 placer_idle,
   output logic                 busy
);

   localparam int unsigned IW = $clog2(NREQ);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] last_gnt_q, last_gnt_d;
   bmp_op_t       op_q, op_d;
   logic [5:0]    indx_q, indx_d;
   logic [9:0]    x_q, x_d;
   logic [8:0]    y_q, y_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic          rsvd_err_q, rsvd_err_d;

   logic          arb_valid;
   logic [IW-1:0] arb_idx;
   logic          grant;
   logic          wd_expired;
   bmp_op_t       sel_op;
   logic [5:0]    sel_indx;
   logic [9:0]    sel_x;
   logic [8:0]    sel_y;
   logic [NREQ-1:0] win_oh;

   rr_arbiter_comb #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr (
      .req      (req),
      .last_gnt (last_gnt_q),
      .valid    (arb_valid),
      .gnt_idx  (arb_idx)
   );

   always_comb begin
      sel_op   = OP_ADD_IMG;
      sel_indx = '0;
      sel_x    = '0;
      sel_y    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (arb_idx == IW'(i)) begin
            sel_op   = bmp_op_t'(cmd_op[2*i +: 2]);
            sel_indx = cmd_indx[6*i +: 6];
            sel_x    = cmd_x[10*i +: 10];
            sel_y    = cmd_y[9*i +: 9];
         end
      end
   end

   // The cycle carrying a reserved-opcode err is held off from granting so ack and err never overlap.
   assign grant      = (state_q == IDLE) && arb_valid && !rsvd_err_q && !rst;
   assign wd_expired = (wd_q == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= IW'(NREQ - 1);
         op_q       <= OP_ADD_IMG;
         indx_q     <= '0;
         x_q        <= '0;
         y_q        <= '0;
         wd_q       <= '0;
         rsvd_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         op_q       <= op_d;
         indx_q     <= indx_d;
         x_q        <= x_d;
         y_q        <= y_d;
         wd_q       <= wd_d;
         rsvd_err_q <= rsvd_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (grant && sel_op != OP_RSVD) state_d = ISSUE;
         ISSUE:      state_d = WAIT_START;
         WAIT_START: state_d = WAIT_DONE;
         WAIT_DONE:  if (placer_idle || wd_expired) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      last_gnt_d = last_gnt_q;
      op_d       = op_q;
      indx_d     = indx_q;
      x_d        = x_q;
      y_d        = y_q;
      rsvd_err_d = 1'b0;
      wd_d       = wd_q;
      if (grant) begin
         last_gnt_d = arb_idx;
         op_d       = sel_op;
         indx_d     = sel_indx;
         x_d        = sel_x;
         y_d        = sel_y;
         rsvd_err_d = (sel_op == OP_RSVD);
      end
      if (state_q == WAIT_START) begin
         wd_d = '0;
      end else if (state_q == WAIT_DONE) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_comb begin
      win_oh     = NREQ'(1) << last_gnt_q;
      ack        = grant ? (NREQ'(1) << arb_idx) : '0;
      done       = (state_q == WAIT_DONE && placer_idle) ? win_oh : '0;
      err        = (rsvd_err_q || (state_q == WAIT_DONE && !placer_idle && wd_expired)) ? win_oh : '0;
      add_img    = (state_q == ISSUE) && (op_q == OP_ADD_IMG);
      rem_img    = (state_q == ISSUE) && (op_q == OP_REM_IMG);
      add_fnt    = (state_q == ISSUE) && (op_q == OP_ADD_FNT);
      image_indx = indx_q[4:0];
      fnt_indx   = indx_q;
      xloc       = x_q;
      yloc       = y_q;
      busy       = (state_q != IDLE);
   end

endmodule

// File: doc/bmp_place_arbiter.md
Name: bmp_place_arbiter

Overview:
- Shares the single bitmap placer engine (image add/remove and font-character draw into videoMem) between NREQ independent requesters, e.g. CPU MMIO, sprite engine and text console.
- Arbitrates round-robin and latches the winning command.
- Issues the one-cycle add_img/rem_img/add_fnt strobe with stable operands, then waits for the placer to return to idle before serving the next requester.
- Reports per-requester accept, done and error, and includes a watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 131072, maximum cycles allowed in WAIT_DONE before the command is abandoned.
- TO_W, $clog2(TIMEOUT+1), width of the watchdog counter (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level; held until ack
- cmd_op  in  2*NREQ  per-requester opcode, slice i = [2i+1:2i]: 00 add_img, 01 rem_img, 10 add_fnt, 11 reserved
- cmd_indx  in  6*NREQ  image index (low 5 bits used) or font index (0..41)
- cmd_x  in  10*NREQ  x location
- cmd_y  in  9*NREQ  y location
- ack  out  NREQ  one-cycle pulse: command latched; requester may drop req or change its command
- done  out  NREQ  one-cycle pulse: placer finished the command
- err  out  NREQ  one-cycle pulse: reserved opcode, or timeout
- add_img  out  1  one-cycle strobe to placer
- rem_img  out  1  one-cycle strobe to placer
- add_fnt  out  1  one-cycle strobe to placer
- image_indx  out  5  latched cmd_indx[4:0]
- fnt_indx  out  6  latched cmd_indx
- xloc  out  10  latched x location
- yloc  out  9  latched y location
- placer_idle  in  1  high when the placer state machine is in IDLE
- busy  out  1  high in every state except IDLE

Behaviour:
Reset (rst high at a clock edge):
- State goes to IDLE.
- All outputs go to 0, including the operand registers.
- Round-robin pointer last_gnt is set to NREQ-1, so requester 0 has top priority after reset.
- Watchdog is cleared.
- rst asserted mid-command abandons the command silently: no done and no err. The placer is not reset by this block.

Arbitration (IDLE, when any req bit is high):
- Winner is the first set bit searching last_gnt+1, last_gnt+2, ... modulo NREQ.
- In the same cycle: latch opcode and operands, pulse ack[winner], set last_gnt = winner.
- If the opcode is 11: also pulse err[winner] next cycle and return to IDLE. No strobe is issued.
- Otherwise go to ISSUE.

States:
- ISSUE:
  - Exactly one of add_img/rem_img/add_fnt is high for exactly one cycle.
  - Operands are already stable on the outputs.
  - Next state is WAIT_START.
- WAIT_START:
  - One-cycle bubble; the placer leaves IDLE on the edge that ends ISSUE, so placer_idle is ignored here.
  - Next state is WAIT_DONE with the watchdog cleared.
- WAIT_DONE:
  - Watchdog increments every cycle.
  - When placer_idle is high: pulse done[winner] and return to IDLE.
  - Otherwise, when the watchdog equals TIMEOUT-1: pulse err[winner] and return to IDLE.
  - If placer_idle is high on the timeout cycle, done wins and err is not pulsed.

Operands and outputs:
- Operand outputs hold their latched values from ISSUE until the next grant.
- ack, done, err and strobes are never asserted together for different requesters.
- At most one of done/err pulses per command.

Timing:
- Minimum command-to-command spacing: the next grant is possible in the IDLE cycle right after done, so there are 4 cycles of arbiter overhead plus the placer's runtime.

Boundary cases:
- A requester that holds req after ack is treated as issuing a new command, served again only after all other pending requesters in rotation.
- req dropping before ack is legal; that request is simply not served.
- Simultaneous req on all inputs: grant order 0,1,2,3,0,... after reset.

Decomposition:
- Shared package bmp_ctrl_pkg:
  - typedef enum logic [1:0] {OP_ADD_IMG, OP_REM_IMG, OP_ADD_FNT, OP_RSVD} bmp_op_t
  - typedef enum {IDLE, ISSUE, WAIT_START, WAIT_DONE} arb_state_t
  - localparam NUM_FONT_CHARS = 42
- One sub-module, rr_arbiter_comb: combinational round-robin pick (req, last_gnt -> valid, gnt_idx). It is reused by later video-path arbiters.

Test Plan:
1. Reset, then req[2]=1 with op=00, indx=5'd1, x=100, y=50 -> ack[2] in the same cycle; add_img pulse 1 cycle later with image_indx=1, xloc=100, yloc=50; hold placer_idle low 20 cycles, then high -> done[2] in that cycle; busy low the next cycle.
2. All four req high with add_fnt commands and placer model idle 3 cycles after each strobe -> grant order 0,1,2,3; each add_fnt preceded by the correct fnt_indx; no overlapping strobes.
3. req[1] held continuously plus req[3] pulsed during requester 1's command -> next grant goes to 3 before 1 is served again.
4. req[0] with op=11 -> ack[0], then err[0] the next cycle; no strobe; busy back to 0 within 2 cycles.
5. With TIMEOUT=16, placer_idle held low after a rem_img strobe -> err pulses exactly 16 cycles after entering WAIT_DONE; no done. Repeat with placer_idle rising on that same cycle -> done only.
6. Assert rst during WAIT_DONE -> all outputs 0 next cycle; no done/err; after release, req[0] wins first.
